// File: rtl/risc_pkg.sv
// Shared opcode, state and width definitions for the
// RISC CPU control path.
package risc_pkg;

  localparam int OP_W   = 3;
  localparam int ST_W   = 3;
  localparam int ADDR_W = 13;

  localparam logic [OP_W-1:0] OP_HLT  = 3'b000;
  localparam logic [OP_W-1:0] OP_SKZ  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_ANDD = 3'b011;
  localparam logic [OP_W-1:0] OP_XORR = 3'b100;
  localparam logic [OP_W-1:0] OP_LDA  = 3'b101;
  localparam logic [OP_W-1:0] OP_STO  = 3'b110;
  localparam logic [OP_W-1:0] OP_JMP  = 3'b111;

  typedef enum logic [ST_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

endpackage

// File: rtl/machine_ctrl_op_class_dec.sv
// Opcode classifier: groups the eight opcodes into the
// behaviour classes the sequencer acts on.
module op_class_dec
  import risc_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  output logic            o_is_alu,
  output logic            o_is_sto,
  output logic            o_is_jmp,
  output logic            o_is_skz,
  output logic            o_is_hlt
);

  always_comb begin
    o_is_alu = 1'b0;
    o_is_sto = 1'b0;
    o_is_jmp = 1'b0;
    o_is_skz = 1'b0;
    o_is_hlt = 1'b0;
    unique case (1'b1)
      i_opcode == OP_HLT:  o_is_hlt = 1'b1;
      i_opcode == OP_SKZ:  o_is_skz = 1'b1;
      i_opcode == OP_ADD,
      i_opcode == OP_ANDD,
      i_opcode == OP_XORR,
      i_opcode == OP_LDA:  o_is_alu = 1'b1;
      i_opcode == OP_STO:  o_is_sto = 1'b1;
      i_opcode == OP_JMP:  o_is_jmp = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/machine_ctrl.sv
// Instruction-sequencing FSM: 8-cycle fetch/execute frame
// per two-byte instruction.
module machine_ctrl
  import risc_pkg::*;
#(
  parameter int OP_W = 3,
  parameter int ST_W = 3
) (
  input  logic            clk_ctrl,
  input  logic            reset,
  input  logic            ena,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            load_ir,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            load_acc,
  output logic            rd,
  output logic            wr,
  output logic            datactl_ena,
  output logic            halt
);

  logic [ST_W-1:0] r_state;
  state_t          w_state;
  state_t          w_next;
  logic            w_alu;
  logic            w_sto;
  logic            w_jmp;
  logic            w_skz;
  logic            w_hlt;

  op_class_dec u_dec (
    .i_opcode (opcode),
    .o_is_alu (w_alu),
    .o_is_sto (w_sto),
    .o_is_jmp (w_jmp),
    .o_is_skz (w_skz),
    .o_is_hlt (w_hlt)
  );

  assign w_state = state_t'(r_state);

  always_ff @(posedge clk_ctrl) begin
    if (reset) r_state <= S0;
    else       r_state <= w_next;
  end

  // Reset and ena=0 both park in S0 with every strobe low.
  always_comb begin
    w_next      = S0;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    if (!reset && ena) begin
      case (w_state)
        S0: begin
          w_next  = S1;
          load_ir = 1'b1;
          rd      = 1'b1;
          inc_pc  = 1'b1;
        end
        S1: begin
          w_next  = S2;
          load_ir = 1'b1;
          rd      = 1'b1;
          inc_pc  = 1'b1;
        end
        S2: w_next = S3;
        S3: begin
          w_next = w_hlt ? S3 : S4;
          halt   = w_hlt;
        end
        S4: begin
          w_next      = S5;
          rd          = w_alu;
          datactl_ena = w_sto;
          load_pc     = w_jmp;
          inc_pc      = w_skz & zero;
        end
        S5: begin
          w_next      = S6;
          rd          = w_alu;
          load_acc    = w_alu;
          wr          = w_sto;
          datactl_ena = w_sto;
        end
        S6: begin
          w_next      = S7;
          datactl_ena = w_sto;
          inc_pc      = w_skz & zero;
        end
        S7: w_next = S0;
        default: w_next = S0;
      endcase
    end
  end

endmodule

// File: doc/machine_ctrl.md
Name: machine_ctrl

Overview:
- Central instruction-sequencing FSM of the RISC CPU. It sits directly downstream of the instruction register and consumes its 3-bit opcode.
- It also generates that register's load_ir strobe.
- It walks an 8-cycle fetch/execute frame per two-byte instruction.
- It drives the PC, accumulator, memory read/write and data-bus tristate enables.

Parameters:
- OP_W, 3, opcode width; must match the instruction register's opcode field.
- ST_W, 3, state register width (8 states S0..S7).

Ports:
- clk_ctrl  input  1  control clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- ena  input  1  run enable from clock/start logic; 0 parks the FSM.
- opcode  input  OP_W  current instruction opcode from the instruction register.
- zero  input  1  accumulator-is-zero flag.
- load_ir  output  1  instruction register byte-load strobe.
- inc_pc  output  1  PC increment.
- load_pc  output  1  PC load from the address field.
- load_acc  output  1  accumulator load from the ALU result.
- rd  output  1  memory read.
- wr  output  1  memory write.
- datactl_ena  output  1  accumulator-to-data-bus tristate enable.
- halt  output  1  CPU halted.

Behaviour:
- Opcodes: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111. ALU class = ADD, ANDD, XORR, LDA.
- Registered 3-bit state. Outputs are a combinational decode of (state, opcode, zero); no other registered outputs.
- Reset: state=S0 at the next edge. With state=S0 and ena=0, all outputs are 0. Reset mid-instruction aborts to S0; the partial instruction is not completed.
- ena=0: next state is S0 regardless of the current state. While ena=0 all outputs are forced to 0, including load_ir in S0. ena has lower priority than reset.
- State transitions with ena=1: S0→S1→…→S7→S0, one state per cycle. Exception: HLT holds in S3.
- Outputs per state (ena=1; any signal not listed is 0):
  - S0 FETCH_HI: load_ir, rd, inc_pc.
  - S1 FETCH_LO: load_ir, rd, inc_pc.
  - S2 IDLE: none. load_ir drops here, which re-arms the instruction register's byte pointer.
  - S3 EXEC1: HLT → halt. Other opcodes → none.
  - S4 EXEC2:
    - ALU → rd.
    - STO → datactl_ena.
    - JMP → load_pc.
    - SKZ and zero=1 → inc_pc.
  - S5 EXEC3:
    - ALU → rd, load_acc.
    - STO → wr, datactl_ena.
  - S6 EXEC4:
    - STO → datactl_ena.
    - SKZ and zero=1 → inc_pc.
  - S7 END: none. Next state is S0.
- load_ir is asserted for exactly two consecutive cycles (S0, S1) and then deasserted.
- The opcode is valid from S1 onward; it is latched at the S0→S1 edge. The decode in S0–S2 must not depend on opcode.
- SKZ with zero=0: no outputs in S3–S7. zero is sampled combinationally in S4 and S6. Verification drives zero stable across the frame.
- wr is never asserted without datactl_ena in the same cycle. rd and wr are never asserted together.
- HLT: the FSM stays in S3 with halt=1 for as long as ena=1. Exit is only via reset or ena=0, both of which go to S0.
- An illegal or unknown state decodes to all outputs 0, with next state S0.

Decomposition:
- Shared package risc_pkg:
  - opcode localparams HLT..JMP;
  - state encodings S0..S7;
  - widths OP_W and the 13-bit address width.
- One natural combinational sub-module, op_class_dec: opcode → is_alu, is_sto, is_jmp, is_skz, is_hlt. machine_ctrl instantiates it.

Test Plan:
- Reset, then ena=1 with opcode=LDA(101):
  - load_ir, rd, inc_pc =1 in S0 and S1;
  - S2 and S3 all 0;
  - S4 rd=1;
  - S5 rd=1 and load_acc=1;
  - back in S0 after 8 cycles.
- opcode=STO(110):
  - datactl_ena=1 in S4–S6;
  - wr=1 only in S5;
  - rd=0 throughout S3–S7.
- opcode=SKZ(001):
  - zero=1 → inc_pc pulses in S4 and S6, 4 inc_pc pulses in total per frame;
  - zero=0 → only the 2 fetch pulses.
- opcode=JMP(111) → load_pc=1 only in S4. opcode=HLT(000) → halt=1 from S3 and held for 20 cycles. Then reset=1 → S0, halt=0.
- Assert reset in S5 of an ADD frame:
  - next cycle state=S0 with all outputs 0 while reset is held;
  - the release cycle restarts the fetch: load_ir=1 for exactly 2 cycles.
- Deassert ena in S4 → next cycle all outputs 0 and state=S0. Reassert ena → a normal frame resumes from S0.
